fsm_seq_counter_param: RTL and testbench
========================================

Name: fsm_seq_counter_param

Overview:
- Parametrised sequence counter. Steps through a programmable table of WIDTH-bit values in a fixed loop instead of a hard-wired non-binary count order.
- Supports start, stop, hold, and skip-ahead by two entries.
- Raises registered flags when a skip lands on a marked table entry and when the loop wraps.
- Sits beside control FSMs as a reusable pattern/sequence generator. Successor to the fixed-sequence FSM counters.

Parameters:
- WIDTH, 8, bit width of table entries and count_out.
- DEPTH, 8, number of table entries; legal range 3..256.
- MARK_IDX, 4, table index whose arrival by skip raises skip_flag; must be < DEPTH.
- IDX_W, $clog2(DEPTH), derived index/address width; not overridden by users.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  IDLE->RUN request; ignored outside IDLE.
- stop  input  1  return to IDLE from RUN or PAUSE.
- hold  input  1  level; freezes sequence while high.
- skip  input  1  advance index by 2 instead of 1.
- wr_en  input  1  table write strobe.
- wr_addr  input  IDX_W  table write index.
- wr_data  input  WIDTH  table write value.
- count_out  output  WIDTH  current sequence value (registered).
- busy  output  1  high in RUN or PAUSE.
- skip_flag  output  1  one-cycle pulse: skip landed on MARK_IDX.
- wrap  output  1  one-cycle pulse: index passed DEPTH-1 back to the start of the table.
- wr_err  output  1  one-cycle pulse: write attempted outside IDLE, or with wr_addr >= DEPTH.

Behaviour:
- Only one clock domain (clk). Reset is asynchronous, active-low (rstn).
- Reset values:
  - State is IDLE; idx=0.
  - All table entries are 0.
  - count_out, busy, skip_flag, wrap and wr_err are all 0.
  - Reset asserted mid-RUN takes effect immediately, regardless of clock.
- States: IDLE, RUN, PAUSE. All outputs are registered.
- IDLE:
  - count_out=0, busy=0.
  - start=1 -> RUN next edge; idx=0 and count_out=table[0] on that edge (1-cycle latency).
  - stop, hold and skip are ignored.
- RUN, priority stop > hold > skip > normal advance:
  - stop: -> IDLE; count_out=0 and idx=0 on the next edge.
  - hold: -> PAUSE; idx and count_out unchanged.
  - skip: idx_n = (idx+2) mod DEPTH.
  - otherwise: idx_n = (idx+1) mod DEPTH.
  - count_out <= table[idx_n] on the same edge.
- PAUSE:
  - count_out and idx are frozen; busy=1.
  - stop -> IDLE.
  - hold=0 -> RUN; advance resumes on the following edge, with no step consumed by the exit.
  - skip is ignored while paused.
- Wrap-around:
  - Asserted when idx+1 or idx+2 >= DEPTH.
  - Skip from DEPTH-2 lands on 0; skip from DEPTH-1 lands on 1; both raise wrap.
  - Normal advance from DEPTH-1 lands on 0 and raises wrap.
- skip_flag: high for exactly the cycle in which count_out first shows table[MARK_IDX] reached via skip. Normal arrival at MARK_IDX does not raise it.
- skip_flag and wrap may be high together (for example, MARK_IDX=0 with a skip from DEPTH-2).
- Table writes:
  - Accepted only in IDLE with wr_addr < DEPTH; table[wr_addr] <= wr_data on that edge.
  - Otherwise the table is unchanged and wr_err pulses on the next cycle.
  - A write in the same cycle as start is accepted, and the RUN sequence uses the new value.
- Arithmetic: index math is done in IDX_W+1 bits before the modulo, so there is no silent overflow when DEPTH is a power of two. Table values pass through unmodified (no arithmetic on data).
- Start pulse while already busy: ignored, with no restart.

Test Plan:
- Reset, then write table 7,1,3,2,5,11,13,17 (DEPTH=8), then start -> count_out 7,1,3,2,5,11,13,17,7,... on successive cycles; wrap=1 only on the cycle showing the second 7; busy=1.
- Skip=1 for one cycle while count_out=3 (idx 2) -> next value 5 (idx 4) with skip_flag=1 (MARK_IDX=4); normal arrival at 5 on the next lap -> skip_flag=0.
- Skip while count_out=17 (idx 7) -> next value 1 (idx 1), wrap=1, skip_flag=0; skip at idx 6 (value 13) -> next value 7, wrap=1.
- hold=1 for 3 cycles while at value 2 -> count_out=2 held for 3 cycles, then resumes at 5; stop during PAUSE -> count_out=0, busy=0 next cycle.
- wr_en during RUN (addr 0, data 99) -> wr_err pulse, table[0] still 7 on the next lap; wr_en in IDLE with wr_addr=8 on a DEPTH=8 build (legal only with IDX_W widened) -> wr_err.
- rstn low mid-RUN between clock edges -> count_out=0 and busy=0 immediately; table reads back as zeros; start after release -> count_out=0 sequence.

Source files
------------

// File: rtl/fsm_seq_counter_param.sv
// Programmable-table sequence counter: steps through DEPTH WIDTH-bit entries with
// start/stop/hold/skip control and registered skip_flag/wrap/wr_err pulses.
module fsm_seq_counter_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int MARK_IDX = 4,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             skip,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             skip_flag,
  output logic             wrap,
  output logic             wr_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [IDX_W:0]   DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] MARK_W  = IDX_W'(MARK_IDX);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_d;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [WIDTH-1:0] count_d, first_val;
  logic [IDX_W:0]   step, sum;
  logic             busy_d, skip_flag_d, wrap_d, wr_err_d, wr_ok;

  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_W);
  // A write landing on entry 0 in the start cycle must be visible immediately
  assign first_val = (wr_ok && wr_addr == '0) ? wr_data : tbl[0];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (stop) state_n = IDLE; else if (hold)  state_n = PAUSE;
      PAUSE:   if (stop) state_n = IDLE; else if (!hold) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // Index math is one bit wider than IDX_W so a power-of-two DEPTH cannot alias
  always_comb begin
    step        = skip ? (IDX_W+1)'(2) : (IDX_W+1)'(1);
    sum         = {1'b0, idx} + step;
    idx_d       = idx;
    count_d     = count_out;
    skip_flag_d = 1'b0;
    wrap_d      = 1'b0;
    case (state)
      IDLE: begin
        idx_d   = '0;
        count_d = start ? first_val : '0;
      end
      RUN:
        if (stop) begin
          idx_d   = '0;
          count_d = '0;
        end else if (!hold) begin
          wrap_d      = (sum >= DEPTH_W);
          idx_d       = wrap_d ? IDX_W'(sum - DEPTH_W) : sum[IDX_W-1:0];
          count_d     = tbl[idx_d];
          skip_flag_d = skip && (idx_d == MARK_W);
        end
      PAUSE:
        if (stop) begin
          idx_d   = '0;
          count_d = '0;
        end
      default: begin
        idx_d   = '0;
        count_d = '0;
      end
    endcase
    busy_d   = (state_n != IDLE);
    wr_err_d = wr_en && !wr_ok;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      idx       <= '0;
      count_out <= '0;
      busy      <= 1'b0;
      skip_flag <= 1'b0;
      wrap      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      idx       <= idx_d;
      count_out <= count_d;
      busy      <= busy_d;
      skip_flag <= skip_flag_d;
      wrap      <= wrap_d;
      wr_err    <= wr_err_d;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_fsm_seq_counter_param.sv
// Directed + randomized bench for fsm_seq_counter_param against a cycle-level
// behavioural model; a second DEPTH=6 instance covers out-of-range writes and flag overlap.
module tb_fsm_seq_counter_param;

  localparam int DEPTH = 8;
  localparam int MARK  = 4;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       start = 0, stop = 0, hold = 0, skip = 0, wr_en = 0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] count_out;
  logic       busy, skip_flag, wrap, wr_err;

  logic       b_start = 0, b_skip = 0, b_wr_en = 0;
  logic [2:0] b_wr_addr = '0;
  logic [7:0] b_wr_data = '0;
  logic [7:0] b_count;
  logic       b_busy, b_skf, b_wrap, b_err;

  int checks = 0, errors = 0;

  // model state
  int m_mode;  // 0 idle, 1 run, 2 pause
  int m_idx;
  int m_tbl [DEPTH];
  int e_cnt, e_busy, e_skf, e_wrap, e_err;

  always #5 clk = ~clk;

  fsm_seq_counter_param #(.WIDTH(8), .DEPTH(DEPTH), .MARK_IDX(MARK)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .hold(hold), .skip(skip),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count_out(count_out),
    .busy(busy), .skip_flag(skip_flag), .wrap(wrap), .wr_err(wr_err));

  fsm_seq_counter_param #(.WIDTH(8), .DEPTH(6), .MARK_IDX(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(b_start), .stop(1'b0), .hold(1'b0), .skip(b_skip),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .count_out(b_count),
    .busy(b_busy), .skip_flag(b_skf), .wrap(b_wrap), .wr_err(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    e_cnt = 0; e_busy = 0; e_skf = 0; e_wrap = 0; e_err = 0;
  endtask

  // One clock of the reference behaviour, from the inputs currently applied
  task automatic model_step();
    bit good;
    int n;
    good   = wr_en && m_mode == 0 && int'(wr_addr) < DEPTH;
    e_err  = (wr_en && !good) ? 1 : 0;
    e_skf  = 0;
    e_wrap = 0;
    if (good) m_tbl[wr_addr] = wr_data;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_idx = 0; e_cnt = m_tbl[0]; end
         else e_cnt = 0;
      1: if (stop) begin m_mode = 0; m_idx = 0; e_cnt = 0; end
         else if (hold) m_mode = 2;
         else begin
           n      = m_idx + (skip ? 2 : 1);
           e_wrap = (n >= DEPTH) ? 1 : 0;
           m_idx  = n % DEPTH;
           e_cnt  = m_tbl[m_idx];
           e_skf  = (skip && m_idx == MARK) ? 1 : 0;
         end
      default: if (stop) begin m_mode = 0; m_idx = 0; e_cnt = 0; end
               else if (!hold) m_mode = 1;
    endcase
    e_busy = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("count_out", 32'(count_out), e_cnt);
    chk("busy",      32'(busy),      e_busy);
    chk("skip_flag", 32'(skip_flag), e_skf);
    chk("wrap",      32'(wrap),      e_wrap);
    chk("wr_err",    32'(wr_err),    e_err);
  endtask

  task automatic bstep();
    model_step();
    @(posedge clk);
    #1;
  endtask

  int tv [8] = '{7, 1, 3, 2, 5, 11, 13, 17};

  initial begin
    model_reset();
    #3;
    chk("rst_count", 32'(count_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_flags", 32'({skip_flag, wrap, wr_err}), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // load table and run one full lap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 8'(tv[i]); step();
    end
    wr_en = 0;
    start = 1; step(); start = 0;
    chk("first_val", 32'(count_out), 7);
    chk("first_busy", 32'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("lap_val",  32'(count_out), 32'(tv[k % 8]));
      chk("lap_wrap", 32'(wrap), (k == 8) ? 1 : 0);
    end

    // skip onto MARK, skip across the end, skip from DEPTH-2
    step(); step();
    skip = 1; step(); skip = 0;
    chk("skip_mark_val", 32'(count_out), 5);
    chk("skip_mark_flag", 32'(skip_flag), 1);
    step(); step(); step();
    skip = 1; step(); skip = 0;
    chk("skip_wrap_val", 32'(count_out), 1);
    chk("skip_wrap_flag", 32'({wrap, skip_flag}), 2'b10);
    step(); step(); step();
    chk("normal_mark_flag", 32'(skip_flag), 0);
    step(); step();
    skip = 1; step(); skip = 0;
    chk("skip_m2_val", 32'(count_out), 7);
    chk("skip_m2_wrap", 32'(wrap), 1);

    // hold at value 2, resume, then stop from PAUSE
    step(); step(); step();
    hold = 1; skip = 1;
    repeat (3) begin step(); chk("hold_val", 32'(count_out), 2); end
    hold = 0; skip = 0; step();
    chk("hold_exit_val", 32'(count_out), 2);
    step();
    chk("resume_val", 32'(count_out), 5);
    hold = 1; step();
    stop = 1; step(); stop = 0; hold = 0;
    chk("stop_pause", 32'({count_out, busy}), 0);

    // write during RUN is rejected
    start = 1; step(); start = 0;
    wr_en = 1; wr_addr = 0; wr_data = 99; step(); wr_en = 0;
    chk("run_wr_err", 32'(wr_err), 1);
    repeat (7) step();
    chk("tbl0_kept", 32'(count_out), 7);
    stop = 1; step(); stop = 0;

    // write in the start cycle is used immediately
    wr_en = 1; wr_addr = 0; wr_data = 42; start = 1; step();
    wr_en = 0; start = 0;
    chk("start_wr_fwd", 32'(count_out), 42);
    stop = 1; step(); stop = 0;

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      start   = ($urandom_range(0, 99) < 20);
      stop    = ($urandom_range(0, 99) < 5);
      hold    = ($urandom_range(0, 99) < 15);
      skip    = ($urandom_range(0, 99) < 30);
      wr_en   = ($urandom_range(0, 99) < 15);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      step();
    end
    {start, stop, hold, skip, wr_en} = '0;

    // async reset mid-RUN
    start = 1; step(); start = 0; step(); step();
    #3 rstn = 1'b0;
    #1;
    chk("async_rst", 32'({count_out, busy}), 0);
    model_reset();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    start = 1; step(); start = 0;
    for (int k = 0; k < 8; k++) begin
      chk("zero_tbl", 32'(count_out), 0);
      step();
    end

    // DEPTH=6, MARK_IDX=0 instance
    for (int i = 0; i < 6; i++) begin
      b_wr_en = 1; b_wr_addr = 3'(i); b_wr_data = 8'(10 + i); bstep();
      chk("b_wr_ok", 32'(b_err), 0);
    end
    b_wr_addr = 6; bstep();
    chk("b_wr_oob6", 32'(b_err), 1);
    b_wr_addr = 7; b_wr_data = 8'hee; bstep(); b_wr_en = 0;
    chk("b_wr_oob7", 32'(b_err), 1);
    b_start = 1; bstep(); b_start = 0;
    chk("b_first", 32'({b_busy, b_count}), {1'b1, 8'd10});
    for (int k = 1; k <= 4; k++) begin
      bstep();
      chk("b_seq", 32'(b_count), 32'(10 + k));
    end
    b_skip = 1; bstep(); b_skip = 0;
    chk("b_skip_both", 32'({b_count, b_skf, b_wrap}), {8'd10, 1'b1, 1'b1});
    bstep();
    chk("b_after", 32'({b_count, b_skf, b_wrap}), {8'd11, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
